green_time_calc: RTL

GREEN_TIME_CALC -- requirements
Module: green_time_calc

---
 rtl/green_timing_pkg.sv | 27 ++
 rtl/car_sensor_sync.sv | 27 ++
 rtl/green_time_calc.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/green_timing_pkg.sv
// Shared FSM state encoding and timing helpers for the adaptive green-time calculator.
package green_timing_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_CLAMP,
      ST_COMMIT
   } calc_state_t;

   // 64-bit intermediate so large clock frequencies times long intervals cannot wrap
   function automatic logic [31:0] ms_to_cyc(input logic [63:0] ms, input logic [63:0] freq);
      return 32'(ms * freq / 64'd1000);
   endfunction

   function automatic logic [31:0] clamp_green(input logic [40:0] value,
                                               input logic [31:0] min_cyc,
                                               input logic [31:0] max_cyc);
      if (value < {9'b0, min_cyc})
         return min_cyc;
      else if (value > {9'b0, max_cyc})
         return max_cyc;
      else
         return value[31:0];
   endfunction

endpackage

// File: rtl/car_sensor_sync.sv
// Two-flop synchroniser plus rising-edge detector for one vehicle-detector input.
module car_sensor_sync (
   input  logic clk,
   input  logic rst,
   input  logic car,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic sync3;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= car;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rise = sync2 & ~sync3;

endmodule

// File: rtl/green_time_calc.sv
// Counts waiting vehicles per direction and computes the next green duration when the opposing green ends.
module green_time_calc
   import green_timing_pkg::*;
#(
   parameter int unsigned CLK_FREQ      = 50_000_000,
   parameter int unsigned BASE_GREEN_MS = 5000,
   parameter int unsigned PER_CAR_MS    = 1000,
   parameter int unsigned MIN_GREEN_MS  = 3000,
   parameter int unsigned MAX_GREEN_MS  = 30000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ns_car,
   input  logic        ew_car,
   input  logic        ns_green,
   input  logic        ew_green,
   output logic [31:0] ns_green_delay,
   output logic [31:0] ew_green_delay,
   output logic        update,
   output logic        busy
);

   localparam logic [31:0] BASE_GREEN_CYC = ms_to_cyc(64'(BASE_GREEN_MS), 64'(CLK_FREQ));
   localparam logic [31:0] PER_CAR_CYC    = ms_to_cyc(64'(PER_CAR_MS), 64'(CLK_FREQ));
   localparam logic [31:0] MIN_GREEN_CYC  = ms_to_cyc(64'(MIN_GREEN_MS), 64'(CLK_FREQ));
   localparam logic [31:0] MAX_GREEN_CYC  = ms_to_cyc(64'(MAX_GREEN_MS), 64'(CLK_FREQ));
   localparam logic [31:0] RESET_CYC      = clamp_green({9'b0, BASE_GREEN_CYC}, MIN_GREEN_CYC, MAX_GREEN_CYC);

   generate
      if (MIN_GREEN_CYC < 32'd1 || MIN_GREEN_CYC > MAX_GREEN_CYC || MAX_GREEN_CYC[31]) begin : g_bad_params
         $error("green_time_calc: illegal MIN/MAX green cycle limits");
      end
   endgenerate

   logic ns_rise;
   logic ew_rise;

   car_sensor_sync u_ns_sync (
      .clk  (clk),
      .rst  (rst),
      .car  (ns_car),
      .rise (ns_rise)
   );

   car_sensor_sync u_ew_sync (
      .clk  (clk),
      .rst  (rst),
      .car  (ew_car),
      .rise (ew_rise)
   );

   logic illegal;
   logic ns_count_en;
   logic ew_count_en;
   logic ns_green_q;
   logic ns_green_qq;
   logic ew_green_q;
   logic ew_green_qq;
   logic ns_req;
   logic ew_req;

   assign illegal     = ns_green & ew_green;
   assign ns_count_en = ns_rise & ~ns_green & ~illegal;
   assign ew_count_en = ew_rise & ~ew_green & ~illegal;
   // The end of one direction's green is the moment to size the other direction's green
   assign ns_req      = ew_green_qq & ~ew_green_q & ~illegal;
   assign ew_req      = ns_green_qq & ~ns_green_q & ~illegal;

   always_ff @(posedge clk) begin
      if (rst) begin
         ns_green_q  <= 1'b0;
         ns_green_qq <= 1'b0;
         ew_green_q  <= 1'b0;
         ew_green_qq <= 1'b0;
      end else begin
         ns_green_q  <= ns_green;
         ns_green_qq <= ns_green_q;
         ew_green_q  <= ew_green;
         ew_green_qq <= ew_green_q;
      end
   end

   logic [7:0] ns_cnt;
   logic [7:0] ew_cnt;

   // A vehicle arriving on the same edge as the snapshot belongs to the next interval
   always_ff @(posedge clk) begin
      if (rst) begin
         ns_cnt <= 8'd0;
         ew_cnt <= 8'd0;
      end else begin
         if (ns_req)
            ns_cnt <= ns_count_en ? 8'd1 : 8'd0;
         else if (ns_count_en && ns_cnt != 8'hFF)
            ns_cnt <= ns_cnt + 8'd1;

         if (ew_req)
            ew_cnt <= ew_count_en ? 8'd1 : 8'd0;
         else if (ew_count_en && ew_cnt != 8'hFF)
            ew_cnt <= ew_cnt + 8'd1;
      end
   end

   calc_state_t state;
   logic [7:0]  ns_snap;
   logic [7:0]  ew_snap;
   logic        ns_pend;
   logic        ew_pend;
   logic        dir_ew;
   logic [7:0]  mult_a;
   logic [39:0] mcand;
   logic [39:0] prod;
   logic [2:0]  bit_cnt;
   logic [31:0] result;

   // Every request records its snapshot and pending flag; IDLE then picks NS before EW
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         ns_snap        <= 8'd0;
         ew_snap        <= 8'd0;
         ns_pend        <= 1'b0;
         ew_pend        <= 1'b0;
         dir_ew         <= 1'b0;
         mult_a         <= 8'd0;
         mcand          <= 40'd0;
         prod           <= 40'd0;
         bit_cnt        <= 3'd0;
         result         <= 32'd0;
         ns_green_delay <= RESET_CYC;
         ew_green_delay <= RESET_CYC;
         update         <= 1'b0;
         busy           <= 1'b0;
      end else begin
         update <= 1'b0;
         if (ns_req) begin
            ns_snap <= ns_cnt;
            ns_pend <= 1'b1;
         end
         if (ew_req) begin
            ew_snap <= ew_cnt;
            ew_pend <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (ns_req || ns_pend) begin
                  state   <= ST_MUL;
                  busy    <= 1'b1;
                  dir_ew  <= 1'b0;
                  mult_a  <= ns_req ? ns_cnt : ns_snap;
                  ns_pend <= 1'b0;
                  mcand   <= {8'b0, PER_CAR_CYC};
                  prod    <= 40'd0;
                  bit_cnt <= 3'd0;
               end else if (ew_req || ew_pend) begin
                  state   <= ST_MUL;
                  busy    <= 1'b1;
                  dir_ew  <= 1'b1;
                  mult_a  <= ew_req ? ew_cnt : ew_snap;
                  ew_pend <= 1'b0;
                  mcand   <= {8'b0, PER_CAR_CYC};
                  prod    <= 40'd0;
                  bit_cnt <= 3'd0;
               end
            end
            ST_MUL: begin
               if (mult_a[0])
                  prod <= prod + mcand;
               mcand   <= mcand << 1;
               mult_a  <= mult_a >> 1;
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state <= ST_CLAMP;
            end
            ST_CLAMP: begin
               result <= clamp_green({9'b0, BASE_GREEN_CYC} + {1'b0, prod}, MIN_GREEN_CYC, MAX_GREEN_CYC);
               state  <= ST_COMMIT;
            end
            ST_COMMIT: begin
               if (dir_ew)
                  ew_green_delay <= result;
               else
                  ns_green_delay <= result;
               update <= 1'b1;
               busy   <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
